// File: rtl/audio_serializer.sv
`timescale 1ns/1ps
// Serial audio output stage: pops signed samples from a show-ahead FIFO, saturates them
// to SAMPLE_BITS and shifts them out left-justified, MSB first, alternating left/right slots.
module audio_serializer #(
    parameter int DATA_WIDTH  = 32,
    parameter int SAMPLE_BITS = 16,
    parameter int CLK_DIV     = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    output logic                  bclk,
    output logic                  lrclk,
    output logic                  sdata,
    output logic [15:0]           underflow_count
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(SAMPLE_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SAMPLE_BITS - 1);
    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX =
        {{(DATA_WIDTH-SAMPLE_BITS+1){1'b0}}, {(SAMPLE_BITS-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state;
    logic [SAMPLE_BITS-1:0] shreg;
    logic [SAMPLE_BITS-1:0] din_sat;
    logic [DIV_W-1:0]       div_cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic                   tick;
    logic                   load_evt;

    always_comb begin
        if ($signed(din) > SAT_MAX)
            din_sat = {1'b0, {(SAMPLE_BITS-1){1'b1}}};
        else if ($signed(din) < SAT_MIN)
            din_sat = {1'b1, {(SAMPLE_BITS-1){1'b0}}};
        else
            din_sat = din[SAMPLE_BITS-1:0];
    end

    assign tick     = (div_cnt == DIV_LAST);
    assign load_evt = (state == RUN) && tick && bclk && (bit_cnt == BIT_LAST);

    // Upstream handshake: din is valid whenever in_empty=0; a word is consumed on every
    // clock edge where in_rd_en=1, and in_rd_en is only raised when a word is valid.
    assign in_rd_en = !reset && !in_empty && ((state == IDLE) || load_evt);

    // Left-justified: the MSB of a freshly loaded word is on sdata the cycle lrclk changes.
    assign sdata = shreg[SAMPLE_BITS-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            shreg           <= '0;
            div_cnt         <= '0;
            bit_cnt         <= '0;
            bclk            <= 1'b0;
            lrclk           <= 1'b0;
            underflow_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bclk    <= 1'b0;
                    lrclk   <= 1'b0;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    if (!in_empty) begin
                        shreg <= din_sat;
                        state <= RUN;
                    end
                end
                RUN: begin
                    div_cnt <= tick ? '0 : div_cnt + 1'b1;
                    if (tick) begin
                        bclk <= ~bclk;
                        // Data only moves on the falling bclk edge so it is stable while bclk is high.
                        if (bclk) begin
                            if (bit_cnt != BIT_LAST) begin
                                shreg   <= {shreg[SAMPLE_BITS-2:0], 1'b0};
                                bit_cnt <= bit_cnt + 1'b1;
                            end else begin
                                bit_cnt <= '0;
                                lrclk   <= ~lrclk;
                                if (!in_empty) begin
                                    shreg <= din_sat;
                                end else begin
                                    shreg <= '0;
                                    if (underflow_count != 16'hFFFF)
                                        underflow_count <= underflow_count + 1'b1;
                                end
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_serializer.sv
`timescale 1ns/1ps
// Bench for audio_serializer: two configurations (default and CLK_DIV=1/SAMPLE_BITS=8), each
// with an upstream FIFO model, a slot-timing reference model feeding exp_q, and a serial monitor.
module tb_audio_serializer;

    logic clock = 1'b0;
    int   total = 0;
    int   bad   = 0;
    bit   done0 = 1'b0;
    bit   done1 = 1'b0;

    always #5 clock = ~clock;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void check_ok(input string name, input bit ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got expired bound or missing item, expected completion at %0t", name, $time);
        end
    endfunction

    // Clamp a signed word to the sb-bit two's complement range, returned as an sb-bit pattern.
    function automatic logic [31:0] sat_ref(input logic [31:0] w, input int sb);
        longint v;
        longint hi;
        v  = longint'($signed(w));
        hi = (longint'(1) <<< (sb - 1)) - 1;
        if (v > hi)
            v = hi;
        else if (v < -hi - 1)
            v = -hi - 1;
        return 32'(v & ((longint'(1) <<< sb) - 1));
    endfunction

    for (genvar g = 0; g < 2; g++) begin : h
        localparam int CD   = (g == 0) ? 4 : 1;
        localparam int SB   = (g == 0) ? 16 : 8;
        localparam int SLOT = 2 * CD * SB;

        logic        reset_s = 1'b1;
        logic        in_empty = 1'b1;
        logic [31:0] din = '0;
        logic        in_rd_en;
        logic        bclk;
        logic        lrclk;
        logic        sdata;
        logic [15:0] underflow_count;

        logic [31:0] fifo_q[$];
        logic [31:0] exp_q[$];
        int          c = 0;
        int          exp_uf = 0;
        bit          running = 1'b0;
        bit          prev_rst = 1'b0;
        bit          pop_pend = 1'b0;
        bit          exp_rd;

        audio_serializer #(
            .DATA_WIDTH (32),
            .SAMPLE_BITS(SB),
            .CLK_DIV    (CD)
        ) dut (
            .clock          (clock),
            .reset          (reset_s),
            .din            (din),
            .in_empty       (in_empty),
            .in_rd_en       (in_rd_en),
            .bclk           (bclk),
            .lrclk          (lrclk),
            .sdata          (sdata),
            .underflow_count(underflow_count)
        );

        function automatic void refresh();
            in_empty = (fifo_q.size() == 0);
            din      = in_empty ? '0 : fifo_q[0];
        endfunction

        task automatic push(input logic [31:0] w);
            fifo_q.push_back(w);
            refresh();
        endtask

        // Reference model: once started, slot boundaries fall every SLOT clocks after the first pop.
        always begin
            @(negedge clock);
            #1;
            check($sformatf("cfg%0d_underflow_count", g), 32'(underflow_count), 32'(exp_uf));
            if (prev_rst || (!reset_s && !running)) begin
                check($sformatf("cfg%0d_idle_bclk", g), 32'(bclk), 32'd0);
                check($sformatf("cfg%0d_idle_lrclk", g), 32'(lrclk), 32'd0);
                check($sformatf("cfg%0d_idle_sdata", g), 32'(sdata), 32'd0);
            end
            exp_rd = 1'b0;
            if (reset_s) begin
                running = 1'b0;
                exp_q.delete();
                exp_uf = 0;
            end else if (!running) begin
                exp_rd = !in_empty;
                if (!in_empty) begin
                    running = 1'b1;
                    c = 0;
                    exp_q.push_back(sat_ref(din, SB));
                end
            end else begin
                c++;
                check($sformatf("cfg%0d_bclk", g), 32'(bclk), 32'(((c - 1) / CD) % 2));
                check($sformatf("cfg%0d_lrclk", g), 32'(lrclk), 32'(((c - 1) / SLOT) % 2));
                if (c % SLOT == 0) begin
                    exp_rd = !in_empty;
                    if (!in_empty) begin
                        exp_q.push_back(sat_ref(din, SB));
                    end else begin
                        exp_q.push_back(32'd0);
                        if (exp_uf < 65535)
                            exp_uf++;
                    end
                end
            end
            check($sformatf("cfg%0d_in_rd_en", g), 32'(in_rd_en), 32'(exp_rd));
            prev_rst = reset_s;
            pop_pend = in_rd_en && !in_empty;
            @(posedge clock);
            #1;
            if (pop_pend) begin
                void'(fifo_q.pop_front());
                refresh();
            end
        end

        logic [31:0] mon_word = '0;
        int          mon_bits = 0;
        bit          mon_ch = 1'b0;
        bit          mon_prev = 1'b0;

        // Monitor: collect sdata on each bclk rise, compare each complete slot with exp_q.
        always begin
            @(negedge clock);
            #1;
            if (reset_s) begin
                mon_bits = 0;
                mon_word = '0;
                mon_ch   = 1'b0;
                mon_prev = 1'b0;
            end else begin
                if (bclk && !mon_prev) begin
                    check($sformatf("cfg%0d_slot_lrclk", g), 32'(lrclk), 32'(mon_ch));
                    mon_word = {mon_word[30:0], sdata};
                    mon_bits++;
                    if (mon_bits == SB) begin
                        check_ok($sformatf("cfg%0d_slot_expected", g), exp_q.size() != 0);
                        if (exp_q.size() != 0)
                            check($sformatf("cfg%0d_slot_word", g), mon_word, exp_q.pop_front());
                        mon_bits = 0;
                        mon_word = '0;
                        mon_ch   = !mon_ch;
                    end
                end
                mon_prev = bclk;
            end
        end

        if (g == 0) begin : stim
            initial begin
                logic [31:0] w;
                logic [15:0] r16;
                bit          hit;
                refresh();
                push(32'h00001234);
                push(32'hFFFF8001);
                push(32'h00012345);
                push(32'hFFFE0000);
                push(32'hFFFF8000);
                push(32'h00007FFF);
                repeat (3) @(negedge clock);
                reset_s = 1'b0;

                hit = 1'b0;
                for (int i = 0; i < 20000; i++) begin
                    @(negedge clock);
                    if (exp_uf >= 3) begin
                        hit = 1'b1;
                        break;
                    end
                end
                check_ok("cfg0_underflow_wait", hit);
                repeat (40) @(negedge clock);
                push(32'h00000ABC);
                repeat (2 * SLOT) @(negedge clock);

                for (int i = 0; i < 24; i++) begin
                    case ($urandom_range(0, 2))
                        0: w = $urandom();
                        1: begin
                            r16 = 16'($urandom());
                            w = {{16{r16[15]}}, r16};
                        end
                        default: w = ($urandom_range(0, 1) != 0) ? 32'(32767 + $urandom_range(0, 2))
                                                                 : 32'(-32769 + $urandom_range(0, 2));
                    endcase
                    push(w);
                end
                repeat (4 * SLOT) @(negedge clock);

                hit = 1'b0;
                for (int i = 0; i < 4 * SLOT; i++) begin
                    @(negedge clock);
                    if (running && (c % (2 * SLOT) == SLOT + 60)) begin
                        hit = 1'b1;
                        break;
                    end
                end
                check_ok("cfg0_right_slot_wait", hit);
                reset_s = 1'b1;
                repeat (3) @(negedge clock);
                reset_s = 1'b0;
                repeat (8 * SLOT) @(negedge clock);
                done0 = 1'b1;
            end
        end else begin : stim
            initial begin
                bit alt;
                alt = 1'b0;
                refresh();
                repeat (2) @(negedge clock);
                reset_s = 1'b0;
                for (int i = 0; i < 400; i++) begin
                    if (fifo_q.size() < 2) begin
                        push(alt ? 32'h0000005A : 32'h000000A5);
                        alt = !alt;
                    end
                    @(negedge clock);
                end
                done1 = 1'b1;
            end
        end
    end

    initial begin
        for (int i = 0; i < 60000 && !(done0 && done1); i++)
            @(negedge clock);
        check_ok("global_timeout", done0 && done1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
